// File: rtl/spi_sec_sync.sv
// spi_sec_sync: SPI secondary (mode 0) running entirely in the clk domain.
// sclk/cs/mosi are oversampled through 2-FF synchronizers; edges on the
// synchronized sclk/cs drive the shift logic three clk after the pin moves.
// Optional feature macro: SPI_SEC_SYNC_ECHO_EN (underrun value = rx_data).
module spi_sec_sync #(
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs,
   input  logic              mosi,
   output logic              miso,
   output logic [DWIDTH-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ack,
   output logic              rx_overrun,
   input  logic [DWIDTH-1:0] tx_data,
   input  logic              tx_wr,
   output logic              tx_ready,
   output logic              tx_underrun
);
   localparam int CW = $clog2(DWIDTH);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t              r_state, w_state_nxt;
   logic [1:0]          r_sclk_sync, r_cs_sync, r_mosi_sync;
   logic                r_sclk_d, r_cs_d;
   logic [CW-1:0]       r_bit_cnt;
   logic [DWIDTH-2:0]   r_rx_shift;
   logic [DWIDTH-1:0]   r_tx_shift, r_tx_hold, r_rx_data;
   logic                r_miso, r_rx_valid, r_rx_overrun, r_tx_ready, r_tx_underrun;

   logic                w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
   logic                w_start, w_stop, w_bit, w_shift_out, w_last, w_load;
   logic [DWIDTH-1:0]   w_rx_word, w_underrun_val, w_load_val;

   // Synchronizers plus the edge-detect delay stage. The cs chain resets low
   // so a pin already held low at reset release never looks like a falling
   // edge; only a fresh high->low transition starts a transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '0;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_cs_d      <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[0], sclk};
         r_cs_sync   <= {r_cs_sync[0], cs};
         r_mosi_sync <= {r_mosi_sync[0], mosi};
         r_sclk_d    <= r_sclk_sync[1];
         r_cs_d      <= r_cs_sync[1];
      end
   end

   assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
   assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;
   assign w_cs_fall   = ~r_cs_sync[1] & r_cs_d;
   assign w_cs_rise   = r_cs_sync[1] & ~r_cs_d;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and per-cycle strobes; sclk edges only count while active
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_stop      = 1'b0;
      w_bit       = 1'b0;
      w_shift_out = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_cs_fall) begin
               w_state_nxt = S_ACTIVE;
               w_start     = 1'b1;
            end
         end
         S_ACTIVE: begin
            if (w_cs_rise) begin
               w_state_nxt = S_IDLE;
               w_stop      = 1'b1;
            end else begin
               w_bit       = w_sclk_rise;
               w_shift_out = w_sclk_fall;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_last    = w_bit & (r_bit_cnt == CW'(DWIDTH-1));
   assign w_load    = w_start | w_last;
   assign w_rx_word = {r_rx_shift, r_mosi_sync[1]};

`ifdef SPI_SEC_SYNC_ECHO_EN
   assign w_underrun_val = r_rx_data;
`else
   assign w_underrun_val = {DWIDTH{1'b1}};
`endif
   assign w_load_val = r_tx_ready ? w_underrun_val : r_tx_hold;

   // Receive shifter and bit counter; a cs release discards the partial word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_shift <= '0;
         r_bit_cnt  <= '0;
      end else if (w_stop) begin
         r_rx_shift <= '0;
         r_bit_cnt  <= '0;
      end else if (w_bit) begin
         r_rx_shift <= w_rx_word[DWIDTH-2:0];
         r_bit_cnt  <= w_last ? '0 : r_bit_cnt + CW'(1);
      end
   end

   // Transmit shifter: first bit goes out at cs fall, later bits on sclk fall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_miso     <= 1'b0;
         r_tx_shift <= '0;
      end else if (w_stop) begin
         r_miso     <= 1'b0;
         r_tx_shift <= '0;
      end else if (w_start) begin
         r_miso     <= w_load_val[DWIDTH-1];
         r_tx_shift <= {w_load_val[DWIDTH-2:0], 1'b0};
      end else if (w_last) begin
         r_tx_shift <= w_load_val;
      end else if (w_shift_out) begin
         r_miso     <= r_tx_shift[DWIDTH-1];
         r_tx_shift <= {r_tx_shift[DWIDTH-2:0], 1'b0};
      end
   end

   // Receive handoff: ack is applied before a same-cycle completed word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_rx_overrun <= 1'b0;
      end else begin
         r_rx_overrun <= 1'b0;
         if (rx_ack) r_rx_valid <= 1'b0;
         if (w_last) begin
            if (r_rx_valid && !rx_ack) begin
               r_rx_overrun <= 1'b1;
            end else begin
               r_rx_data  <= w_rx_word;
               r_rx_valid <= 1'b1;
            end
         end
      end
   end

   // Holding register: a same-cycle write refills it after the load took it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_hold     <= '0;
         r_tx_ready    <= 1'b1;
         r_tx_underrun <= 1'b0;
      end else begin
         r_tx_underrun <= w_load & r_tx_ready;
         if (tx_wr) begin
            r_tx_hold  <= tx_data;
            r_tx_ready <= 1'b0;
         end else if (w_load) begin
            r_tx_ready <= 1'b1;
         end
      end
   end

   assign miso        = r_miso;
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign rx_overrun  = r_rx_overrun;
   assign tx_ready    = r_tx_ready;
   assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_sec_sync.sv
// Bench for spi_sec_sync: a bit-banged SPI master plus a transaction-level
// model of the holding register and receive handoff.
module tb_spi_sec_sync;
   localparam int DW = 8;

   logic          clk = 1'b0, rst = 1'b1;
   logic          sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
   logic          rx_ack = 1'b0, tx_wr = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic          miso, rx_valid, rx_overrun, tx_ready, tx_underrun;
   logic [DW-1:0] rx_data;

   int total = 0, bad = 0;
   int n_ovr = 0, n_und = 0;

   // reference model state
   logic [DW-1:0] m_hold = '0, m_rx_data = '0, m_tx_cur = '0;
   bit            m_full = 1'b0, m_rx_valid = 1'b0;
   int            m_ovr = 0, m_und = 0;

   spi_sec_sync #(.DWIDTH(DW)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
      .rx_overrun(rx_overrun), .tx_data(tx_data), .tx_wr(tx_wr),
      .tx_ready(tx_ready), .tx_underrun(tx_underrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rx_overrun)  n_ovr <= n_ovr + 1;
      if (tx_underrun) n_und <= n_und + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // model: value the secondary will shift out for the next word
   task automatic m_load(output logic [DW-1:0] v);
      if (m_full) begin
         v      = m_hold;
         m_full = 1'b0;
      end else begin
`ifdef SPI_SEC_SYNC_ECHO_EN
         v = m_rx_data;
`else
         v = '1;
`endif
         m_und++;
      end
   endtask

   // model: word delivered, optionally with a same-cycle ack
   task automatic m_word(input logic [DW-1:0] w, input bit ack);
      if (ack) m_rx_valid = 1'b0;
      if (m_rx_valid) m_ovr++;
      else begin
         m_rx_data  = w;
         m_rx_valid = 1'b1;
      end
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_rx_data"},  32'(rx_data),  32'(m_rx_data));
      chk({tag, "_rx_valid"}, 32'(rx_valid), 32'(m_rx_valid));
      chk({tag, "_tx_ready"}, 32'(tx_ready), 32'(!m_full));
      chk({tag, "_overruns"}, 32'(n_ovr),    32'(m_ovr));
      chk({tag, "_underruns"},32'(n_und),    32'(m_und));
   endtask

   task automatic wr_tx(input logic [DW-1:0] d);
      @(negedge clk);
      tx_data = d;
      tx_wr   = 1'b1;
      @(negedge clk);
      tx_wr  = 1'b0;
      m_hold = d;
      m_full = 1'b1;
      chk("tx_ready_after_wr", 32'(tx_ready), 32'(0));
   endtask

   task automatic do_ack();
      @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack     = 1'b0;
      m_rx_valid = 1'b0;
      chk("rx_valid_after_ack", 32'(rx_valid), 32'(0));
   endtask

   task automatic cs_fall();
      @(negedge clk);
      cs = 1'b0;
      m_load(m_tx_cur);
   endtask

   task automatic cs_rise();
      nclk(2);
      cs = 1'b1;
      nclk(5);
      chk("miso_idle", 32'(miso), 32'(0));
   endtask

   // master: nb bits MSB first, miso sampled just before each rising edge
   task automatic xfer(input logic [DW-1:0] w, input int nb, input bit ack_last,
                       output logic [DW-1:0] got);
      got = '0;
      for (int i = DW-1; i >= DW-nb; i--) begin
         mosi = w[i];
         nclk(4);
         got[i] = miso;
         sclk = 1'b1;
         if (ack_last && i == 0) begin
            nclk(2);
            rx_ack = 1'b1;
            nclk(1);
            rx_ack = 1'b0;
            nclk(1);
         end else begin
            nclk(4);
         end
         sclk = 1'b0;
      end
   endtask

   task automatic word(input logic [DW-1:0] w, input bit ack_last, input string tag);
      logic [DW-1:0] got, exp_tx;
      exp_tx = m_tx_cur;
      xfer(w, DW, ack_last, got);
      chk(tag, 32'(got), 32'(exp_tx));
      m_load(m_tx_cur);
      m_word(w, ack_last);
   endtask

   initial begin
      logic [DW-1:0] got;
      int nw;
      nclk(3);
      rst = 1'b0;
      nclk(2);
      chk("rst_miso", 32'(miso), 32'(0));
      chk("rst_rx_data", 32'(rx_data), 32'(0));
      chk("rst_rx_valid", 32'(rx_valid), 32'(0));
      chk("rst_rx_overrun", 32'(rx_overrun), 32'(0));
      chk("rst_tx_ready", 32'(tx_ready), 32'(1));
      chk("rst_tx_underrun", 32'(tx_underrun), 32'(0));

      // basic word, with cs-to-miso latency
      wr_tx(8'hA5);
      cs_fall();
      nclk(2);
      chk("miso_lat_early", 32'(miso), 32'(0));
      nclk(1);
      chk("miso_lat", 32'(miso), 32'(1));
      chk("tx_ready_after_load", 32'(tx_ready), 32'(1));
      word(8'h3C, 1'b0, "miso_a5");
      chk("rx_3c", 32'(rx_data), 32'(8'h3C));
      cs_rise();
      check_state("basic");
      do_ack();

      // back-to-back words without ack -> overrun
      cs_fall();
      word(8'h11, 1'b0, "miso_w11");
      word(8'h22, 1'b0, "miso_w22");
      cs_rise();
      chk("ovr_rx_11", 32'(rx_data), 32'(8'h11));
      check_state("overrun");
      do_ack();

      // underrun value after a prior receive of 0x5A
      cs_fall();
      word(8'h5A, 1'b0, "miso_pre5a");
      cs_rise();
      do_ack();
      cs_fall();
      xfer(8'h00, DW, 1'b0, got);
`ifdef SPI_SEC_SYNC_ECHO_EN
      chk("underrun_val", 32'(got), 32'(8'h5A));
`else
      chk("underrun_val", 32'(got), 32'(8'hFF));
`endif
      m_load(m_tx_cur);
      m_word(8'h00, 1'b0);
      cs_rise();
      check_state("underrun");
      do_ack();

      // partial word aborted by cs, then a full word
      cs_fall();
      xfer(8'hF0, 5, 1'b0, got);
      cs_rise();
      chk("partial_no_valid", 32'(rx_valid), 32'(0));
      cs_fall();
      word(8'h81, 1'b0, "miso_w81");
      cs_rise();
      chk("rx_81", 32'(rx_data), 32'(8'h81));
      check_state("partial");

      // completed word coinciding with ack while 0x81 is pending
      wr_tx(8'h96);
      cs_fall();
      word(8'h77, 1'b1, "miso_coll");
      cs_rise();
      chk("coll_rx_77", 32'(rx_data), 32'(8'h77));
      check_state("collision");

      // reset mid-word with cs held low
      cs_fall();
      xfer(8'hC3, 4, 1'b0, got);
      @(negedge clk);
      rst = 1'b1;
      nclk(2);
      rst = 1'b0;
      m_full = 1'b0; m_rx_valid = 1'b0; m_rx_data = '0;
      nclk(2);
      chk("rstmid_miso", 32'(miso), 32'(0));
      check_state("rstmid");
      xfer(8'hE7, DW, 1'b0, got);
      nclk(4);
      chk("rstmid_miso_quiet", 32'(got), 32'(0));
      check_state("rstmid_after");
      cs_rise();
      cs_fall();
      word(8'h42, 1'b0, "miso_post_rst");
      cs_rise();
      check_state("post_rst");

      // randomized sessions
      for (int s = 0; s < 6; s++) begin
         if ($urandom_range(1, 0) == 1) wr_tx(DW'($urandom));
         cs_fall();
         nw = int'($urandom_range(3, 1));
         for (int k = 0; k < nw; k++) begin
            word(DW'($urandom), ($urandom_range(3, 0) == 0), "miso_rand");
            if ($urandom_range(1, 0) == 1) wr_tx(DW'($urandom));
            if ($urandom_range(2, 0) == 0) do_ack();
         end
         cs_rise();
         check_state("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
